ra_bist: RTL



---
 rtl/ra_bist_pkg.sv | 73 +++++++
 rtl/ra_bist_patgen.sv | 36 +++
 rtl/ra_bist.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ra_bist_pkg.sv
// ra_bist_pkg: shared definitions for the ra_bist March C- engine.
// Holds the bist_ctl / bist_status bit positions, the March element codes
// (which are also the fail_elem encoding), the pattern select codes, the FSM
// state encoding and small per-element helper functions.
package ra_bist_pkg;

    // bist_ctl bit positions
    localparam int CTL_START  = 0;
    localparam int CTL_ABORT  = 1;
    localparam int CTL_STOP   = 2;
    localparam int CTL_CHK_R1 = 3;
    localparam int CTL_PAT_LO = 4;
    localparam int CTL_PAT_HI = 5;

    // bist_status bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_FAIL    = 2;
    localparam int ST_ELEM_LO = 4;
    localparam int ST_ADR_LO  = 8;
    localparam int ST_CNT_LO  = 16;
    localparam int ST_FAIL_R0 = 24;
    localparam int ST_FAIL_R1 = 25;

    // March C- elements; the value is reported in fail_elem
    typedef enum logic [2:0] {
        ELEM_E0 = 3'd0,  // up,   W D0
        ELEM_E1 = 3'd1,  // up,   R D0, W D1
        ELEM_E2 = 3'd2,  // up,   R D1, W D0
        ELEM_E3 = 3'd3,  // down, R D0, W D1
        ELEM_E4 = 3'd4,  // down, R D1, W D0
        ELEM_E5 = 3'd5   // down, R D0
    } elem_e;

    // Background pattern selects (D0); D1 is always ~D0
    typedef enum logic [1:0] {
        PAT_ZERO = 2'd0,
        PAT_55   = 2'd1,
        PAT_ADR  = 2'd2,
        PAT_0F   = 2'd3
    } pat_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_CMP  = 3'd4,
        S_NEXT = 3'd5,
        S_DONE = 3'd6
    } state_e;

    // Down elements walk the address space from the top
    function automatic logic elem_down(input elem_e e);
        return (e == ELEM_E3) || (e == ELEM_E4) || (e == ELEM_E5);
    endfunction

    // Every element except the final read-only sweep writes
    function automatic logic elem_has_write(input elem_e e);
        return (e != ELEM_E5);
    endfunction

    // Polarity expected on the read of an element (1 = D1)
    function automatic logic elem_rd_pol(input elem_e e);
        return (e == ELEM_E2) || (e == ELEM_E4);
    endfunction

    // Polarity written by an element (1 = D1)
    function automatic logic elem_wr_pol(input elem_e e);
        return (e == ELEM_E1) || (e == ELEM_E3);
    endfunction

endpackage

// File: rtl/ra_bist_patgen.sv
// ra_bist_patgen: combinational expected/write data generator.
// Produces D0 for the selected background at a given address, or D1 = ~D0
// when pol is set. The address pattern packs as many whole copies of the
// address as fit in DW and leaves the remaining top bits zero.
import ra_bist_pkg::*;

module ra_bist_patgen #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  pat_e          pat,
    input  logic [AW-1:0] adr,
    input  logic          pol,
    output logic [DW-1:0] dat
);

    logic [DW-1:0] rep_s;
    logic [DW-1:0] base_s;

    // Build the background word and apply the requested polarity
    always_comb begin
        rep_s = '0;
        for (int i = 0; i < DW / AW; i++) begin
            rep_s[i*AW +: AW] = adr;
        end
        case (pat)
            PAT_ZERO: base_s = '0;
            PAT_55:   base_s = {(DW/2){2'b01}};
            PAT_ADR:  base_s = rep_s;
            PAT_0F:   base_s = {(DW/8){8'h0F}};
            default:  base_s = '0;
        endcase
        dat = pol ? ~base_s : base_s;
    end

endmodule

// File: rtl/ra_bist.sv
// ra_bist: March C- self-test engine and array port mux.
// While busy the engine owns the r0/r1/w0 array ports; otherwise the
// functional ports from control pass straight through. All status is held
// in flops and assembled into bist_status.
// Optional build macro RA_BIST_DIAG_EN: captures the expected and observed
// data of the first mismatch on fail_exp/fail_got (tied to zero otherwise).
import ra_bist_pkg::*;

module ra_bist #(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   bist_ctl,
    output logic [31:0]   bist_status,
    input  logic          f_r0_enb,
    input  logic          f_r1_enb,
    input  logic          f_w0_enb,
    input  logic [AW-1:0] f_r0_adr,
    input  logic [AW-1:0] f_r1_adr,
    input  logic [AW-1:0] f_w0_adr,
    input  logic [DW-1:0] f_w0_dat,
    output logic          ra_r0_enb,
    output logic          ra_r1_enb,
    output logic          ra_w0_enb,
    output logic [AW-1:0] ra_r0_adr,
    output logic [AW-1:0] ra_r1_adr,
    output logic [AW-1:0] ra_w0_adr,
    output logic [DW-1:0] ra_w0_dat,
    input  logic [DW-1:0] ra_r0_dat,
    input  logic [DW-1:0] ra_r1_dat,
    output logic [DW-1:0] fail_exp,
    output logic [DW-1:0] fail_got
);

    localparam int WCW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
    localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);
    localparam logic [AW-1:0]  ADR_ONE   = AW'(1);

    state_e         state_q, state_d;
    elem_e          elem_q, elem_d;
    logic [AW-1:0]  adr_q, adr_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           start_prev_q, start_prev_d;
    pat_e           pat_q, pat_d;
    logic           chk_r1_q, chk_r1_d;
    logic           stop_q, stop_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           fail_q, fail_d;
    logic [2:0]     fail_elem_q, fail_elem_d;
    logic [AW-1:0]  fail_adr_q, fail_adr_d;
    logic [7:0]     fail_cnt_q, fail_cnt_d;
    logic           fail_r0_q, fail_r0_d;
    logic           fail_r1_q, fail_r1_d;

    logic           start_edge_s;
    logic           go_done_s;
    logic           pat_pol_s;
    logic [DW-1:0]  pat_dat_s;
    logic           mis_r0_s;
    logic           mis_r1_s;
    logic           first_mis_s;
    logic           ctl_unused_s;

    assign ctl_unused_s = ^bist_ctl[31:6];
    assign start_edge_s = bist_ctl[CTL_START] & ~start_prev_q;

    // Writes use the element's write polarity, every other state the read one
    assign pat_pol_s = (state_q == S_WR) ? elem_wr_pol(elem_q) : elem_rd_pol(elem_q);

    ra_bist_patgen #(
        .AW (AW),
        .DW (DW)
    ) u_patgen (
        .pat (pat_q),
        .adr (adr_q),
        .pol (pat_pol_s),
        .dat (pat_dat_s)
    );

    assign mis_r0_s    = (ra_r0_dat != pat_dat_s);
    assign mis_r1_s    = chk_r1_q && (ra_r1_dat != pat_dat_s);
    assign first_mis_s = (state_q == S_CMP) && (mis_r0_s || mis_r1_s) && !fail_q;

    // Next-state, address walk and status update
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        adr_d        = adr_q;
        wait_d       = wait_q;
        start_prev_d = bist_ctl[CTL_START];
        pat_d        = pat_q;
        chk_r1_d     = chk_r1_q;
        stop_d       = stop_q;
        busy_d       = busy_q;
        done_d       = done_q;
        fail_d       = fail_q;
        fail_elem_d  = fail_elem_q;
        fail_adr_d   = fail_adr_q;
        fail_cnt_d   = fail_cnt_q;
        fail_r0_d    = fail_r0_q;
        fail_r1_d    = fail_r1_q;
        go_done_s    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge_s) begin
                    state_d     = S_WR;
                    elem_d      = ELEM_E0;
                    adr_d       = '0;
                    wait_d      = '0;
                    pat_d       = pat_e'(bist_ctl[CTL_PAT_HI:CTL_PAT_LO]);
                    chk_r1_d    = bist_ctl[CTL_CHK_R1];
                    stop_d      = bist_ctl[CTL_STOP];
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_elem_d = 3'd0;
                    fail_adr_d  = '0;
                    fail_cnt_d  = 8'd0;
                    fail_r0_d   = 1'b0;
                    fail_r1_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_WR: begin
                state_d = S_NEXT;
            end
            S_RD: begin
                wait_d = '0;
                if (RD_LAT > 1) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_CMP;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_CMP;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_CMP: begin
                if (mis_r0_s || mis_r1_s) begin
                    fail_d    = 1'b1;
                    fail_r0_d = fail_r0_q | mis_r0_s;
                    fail_r1_d = fail_r1_q | mis_r1_s;
                    if (fail_cnt_q != 8'hFF) begin
                        fail_cnt_d = fail_cnt_q + 8'd1;
                    end else begin
                        fail_cnt_d = fail_cnt_q;
                    end
                    if (!fail_q) begin
                        fail_elem_d = elem_q;
                        fail_adr_d  = adr_q;
                    end else begin
                        fail_elem_d = fail_elem_q;
                    end
                end else begin
                    fail_d = fail_q;
                end
                if ((mis_r0_s || mis_r1_s) && stop_q) begin
                    go_done_s = 1'b1;
                end else if (elem_has_write(elem_q)) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (elem_down(elem_q) ? (adr_q == '0) : (adr_q == '1)) begin
                    if (elem_q == ELEM_E5) begin
                        go_done_s = 1'b1;
                    end else begin
                        // every element after E0 opens with a read
                        elem_d  = elem_e'(elem_q + 3'd1);
                        adr_d   = elem_down(elem_d) ? '1 : '0;
                        state_d = S_RD;
                    end
                end else begin
                    adr_d   = elem_down(elem_q) ? (adr_q - ADR_ONE) : (adr_q + ADR_ONE);
                    state_d = (elem_q == ELEM_E0) ? S_WR : S_RD;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // abort wins over whatever transition the running state chose
        if (busy_q && bist_ctl[CTL_ABORT]) begin
            go_done_s = 1'b1;
        end else begin
            go_done_s = go_done_s;
        end

        if (go_done_s) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end else begin
            state_d = state_d;
        end
    end

    // Engine state and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            elem_q       <= ELEM_E0;
            adr_q        <= '0;
            wait_q       <= '0;
            start_prev_q <= 1'b0;
            pat_q        <= PAT_ZERO;
            chk_r1_q     <= 1'b0;
            stop_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_elem_q  <= 3'd0;
            fail_adr_q   <= '0;
            fail_cnt_q   <= 8'd0;
            fail_r0_q    <= 1'b0;
            fail_r1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            adr_q        <= adr_d;
            wait_q       <= wait_d;
            start_prev_q <= start_prev_d;
            pat_q        <= pat_d;
            chk_r1_q     <= chk_r1_d;
            stop_q       <= stop_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            fail_elem_q  <= fail_elem_d;
            fail_adr_q   <= fail_adr_d;
            fail_cnt_q   <= fail_cnt_d;
            fail_r0_q    <= fail_r0_d;
            fail_r1_q    <= fail_r1_d;
        end
    end

    assign bist_status = {6'd0, fail_r1_q, fail_r0_q, fail_cnt_q, 3'd0, fail_adr_q,
                          1'b0, fail_elem_q, 1'b0, fail_q, done_q, busy_q};

    // Array port mux: engine owns the ports only while busy
    always_comb begin
        if (busy_q) begin
            ra_r0_enb = (state_q == S_RD);
            ra_r1_enb = (state_q == S_RD) && chk_r1_q;
            ra_w0_enb = (state_q == S_WR);
            ra_r0_adr = adr_q;
            ra_r1_adr = adr_q;
            ra_w0_adr = adr_q;
            ra_w0_dat = pat_dat_s;
        end else begin
            ra_r0_enb = f_r0_enb;
            ra_r1_enb = f_r1_enb;
            ra_w0_enb = f_w0_enb;
            ra_r0_adr = f_r0_adr;
            ra_r1_adr = f_r1_adr;
            ra_w0_adr = f_w0_adr;
            ra_w0_dat = f_w0_dat;
        end
    end

`ifdef RA_BIST_DIAG_EN
    logic [DW-1:0] fail_exp_q, fail_exp_d;
    logic [DW-1:0] fail_got_q, fail_got_d;

    // Capture expected/observed data of the first mismatch, clear on start
    always_comb begin
        fail_exp_d = fail_exp_q;
        fail_got_d = fail_got_q;
        if (start_edge_s && !busy_q) begin
            fail_exp_d = '0;
            fail_got_d = '0;
        end else if (first_mis_s) begin
            fail_exp_d = pat_dat_s;
            fail_got_d = mis_r0_s ? ra_r0_dat : ra_r1_dat;
        end else begin
            fail_exp_d = fail_exp_q;
        end
    end

    // Diagnostic capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_exp_q <= '0;
            fail_got_q <= '0;
        end else begin
            fail_exp_q <= fail_exp_d;
            fail_got_q <= fail_got_d;
        end
    end

    assign fail_exp = fail_exp_q;
    assign fail_got = fail_got_q;
`else
    logic diag_unused_s;
    assign diag_unused_s = first_mis_s;
    assign fail_exp      = '0;
    assign fail_got      = '0;
`endif

endmodule
